// File: rtl/heartbeat_demux.sv
// Steers each AXI-Stream packet to SFP or one of three heartbeat sinks, decoded from the first beat.
// Optional drop counter is enabled by defining HEARTBEAT_DEMUX_DROP_CNT_EN; otherwise drop_count is 0.
module heartbeat_demux #(
  parameter int          DATA_WIDTH   = 512,
  parameter int          KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter logic [15:0] HB_ETHERTYPE = 16'h88B5,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_sfp_tvalid,
  input  logic                  m_axis_sfp_tready,
  output logic                  m_axis_hb1_tvalid,
  input  logic                  m_axis_hb1_tready,
  output logic                  m_axis_hb2_tvalid,
  input  logic                  m_axis_hb2_tready,
  output logic                  m_axis_hb3_tvalid,
  input  logic                  m_axis_hb3_tready,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                state_q;
  logic [1:0]            route_q;
  logic                  ready_en_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic [1:0]            out_sel_q;

  logic [15:0] ethertype;
  logic [7:0]  hb_id;
  logic [1:0]  hdr_route;
  logic        hdr_drop;
  logic        sel_ready;
  logic        accept;
  logic        load;
  logic [1:0]  load_sel;

  // Byte k of the beat sits in tdata[8k +: 8]; the EtherType is big-endian on the wire.
  assign ethertype = {s_axis_tdata[96 +: 8], s_axis_tdata[104 +: 8]};
  assign hb_id     = s_axis_tdata[112 +: 8];

  always_comb begin
    hdr_route = 2'd0;
    hdr_drop  = 1'b0;
    if (s_axis_tkeep[14] && (ethertype == HB_ETHERTYPE)) begin
      if (hb_id inside {8'd1, 8'd2, 8'd3}) hdr_route = hb_id[1:0];
      else                                 hdr_drop  = 1'b1;
    end
  end

  always_comb begin
    case (out_sel_q)
      2'd0:    sel_ready = m_axis_sfp_tready;
      2'd1:    sel_ready = m_axis_hb1_tready;
      2'd2:    sel_ready = m_axis_hb2_tready;
      default: sel_ready = m_axis_hb3_tready;
    endcase
  end

  assign s_axis_tready = ready_en_q && ((state_q == DROP) || !out_valid_q || sel_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = accept && ((state_q == FWD) || ((state_q == IDLE) && !hdr_drop));
  assign load_sel      = (state_q == FWD) ? route_q : hdr_route;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      route_q     <= 2'd0;
      ready_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      ready_en_q <= 1'b1;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= s_axis_tdata;
        out_keep_q  <= s_axis_tkeep;
        out_last_q  <= s_axis_tlast;
        out_sel_q   <= load_sel;
      end else if (sel_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (hdr_drop) begin
              state_q <= s_axis_tlast ? IDLE : DROP;
            end else if (!s_axis_tlast) begin
              state_q <= FWD;
              route_q <= hdr_route;
            end
          end
          FWD, DROP: if (s_axis_tlast) state_q <= IDLE;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_tdata      = out_data_q;
  assign m_axis_tkeep      = out_keep_q;
  assign m_axis_tlast      = out_last_q;
  assign m_axis_sfp_tvalid = out_valid_q && (out_sel_q == 2'd0);
  assign m_axis_hb1_tvalid = out_valid_q && (out_sel_q == 2'd1);
  assign m_axis_hb2_tvalid = out_valid_q && (out_sel_q == 2'd2);
  assign m_axis_hb3_tvalid = out_valid_q && (out_sel_q == 2'd3);

`ifdef HEARTBEAT_DEMUX_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  // Counts packets, not beats: only the first beat of a dropped packet is seen in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && (state_q == IDLE) && hdr_drop && !(&drop_cnt_q)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_heartbeat_demux.sv
// Randomized bench for heartbeat_demux: packets are routed by a packet-level model into an
// expected-beat queue which every output handshake is compared against.
module tb_heartbeat_demux;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          sfp_v, hb1_v, hb2_v, hb3_v;
  logic          sfp_r = 1'b1, hb1_r = 1'b1, hb2_r = 1'b1, hb3_r = 1'b1;
  logic [CW-1:0] drop_count;

  always #5 clk = ~clk;

  heartbeat_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_sfp_tvalid(sfp_v), .m_axis_sfp_tready(sfp_r),
    .m_axis_hb1_tvalid(hb1_v), .m_axis_hb1_tready(hb1_r),
    .m_axis_hb2_tvalid(hb2_v), .m_axis_hb2_tready(hb2_r),
    .m_axis_hb3_tvalid(hb3_v), .m_axis_hb3_tready(hb3_r),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    bit            isdrop;
  } src_beat_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    int            sel;
  } exp_beat_t;

  src_beat_t src_q[$];
  exp_beat_t exp_q[$];
  int        exp_drops = 0;
  bit        in_drop = 0;
  int        n_checks = 0;
  int        n_pass = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Packet-level model: route from the header rules, then queue every beat the sink must see.
  task automatic add_pkt(input logic [15:0] et, input logic [7:0] id, input int nb, input bit runt);
    int route;
    bit drop;
    drop  = 0;
    route = 0;
    if (!runt && et == 16'h88B5) begin
      if (id >= 8'd1 && id <= 8'd3) route = int'(id);
      else drop = 1;
    end
    if (drop) begin
`ifdef HEARTBEAT_DEMUX_DROP_CNT_EN
      if (exp_drops < (1 << CW) - 1) exp_drops++;
`endif
    end
    for (int b = 0; b < nb; b++) begin
      src_beat_t s;
      exp_beat_t e;
      for (int w = 0; w < DW / 32; w++) s.d[w*32 +: 32] = $urandom;
      if (b == 0) begin
        s.d[96 +: 8]  = et[15:8];
        s.d[104 +: 8] = et[7:0];
        s.d[112 +: 8] = id;
        s.k = '1;
        if (runt) s.k[14] = 1'b0;
      end else begin
        s.k = {$urandom, $urandom};
        if (s.k == '0) s.k[0] = 1'b1;
      end
      s.l = (b == nb - 1);
      s.isdrop = drop;
      src_q.push_back(s);
      if (!drop) begin
        e.d = s.d; e.k = s.k; e.l = s.l; e.sel = route;
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: all sinks ready, source always valid; 1: random; 2: hb1 stalls 5 of every 8 cycles.
  task automatic run(input int mode, input int stop_at);
    int  cyc = 0;
    bit  prev_acc = 0;
    while (!(src_q.size() <= stop_at && (stop_at > 0 || exp_q.size() == 0))) begin
      logic [3:0] v;
      int         sel;
      bit         selrdy, xfer;
      if (cyc >= 2000) begin
        check_val("timeout", 1, 0);
        break;
      end
      @(negedge clk);
      s_tvalid = (src_q.size() > 0) && (mode == 0 || $urandom_range(3) != 0);
      if (src_q.size() > 0) begin
        s_tdata = src_q[0].d; s_tkeep = src_q[0].k; s_tlast = src_q[0].l;
      end
      case (mode)
        0: begin sfp_r = 1; hb1_r = 1; hb2_r = 1; hb3_r = 1; end
        2: begin
          sfp_r = 1'($urandom_range(1)); hb2_r = 1'($urandom_range(1)); hb3_r = 1'($urandom_range(1));
          hb1_r = (cyc % 8) >= 5;
        end
        default: begin
          sfp_r = 1'($urandom_range(1)); hb1_r = 1'($urandom_range(1));
          hb2_r = 1'($urandom_range(1)); hb3_r = 1'($urandom_range(1));
        end
      endcase
      #1;
      v   = {hb3_v, hb2_v, hb1_v, sfp_v};
      sel = hb3_v ? 3 : hb2_v ? 2 : hb1_v ? 1 : 0;
      selrdy = (sel == 0) ? sfp_r : (sel == 1) ? hb1_r : (sel == 2) ? hb2_r : hb3_r;
      xfer = (|v) && selrdy;
      check_val("onehot", DW'($countones(v) <= 1), 1);
      if (mode == 0 && prev_acc) check_val("latency", DW'(xfer), 1);
      if (in_drop) check_val("drop_rdy", DW'(s_tready), 1);
      else if ((|v) && !selrdy) check_val("stall_rdy", DW'(s_tready), 0);
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check_val("spurious", 1, 0);
        end else begin
          exp_beat_t e;
          e = exp_q.pop_front();
          check_val("sel", DW'(sel), DW'(e.sel));
          check_val("last", DW'(m_tlast), DW'(e.l));
          check_val("keep", DW'(m_tkeep), DW'(e.k));
          check_val("data", m_tdata, e.d);
        end
      end
      prev_acc = 0;
      if (s_tvalid && s_tready) begin
        src_beat_t b;
        b = src_q.pop_front();
        prev_acc = !b.isdrop;
        in_drop = b.isdrop && !b.l;
      end
      cyc++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valids", DW'({hb3_v, hb2_v, hb1_v, sfp_v}), 0);
    check_val("rst_drops", DW'(drop_count), 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_tready", DW'(s_tready), 1);

    // Directed frames from the plan.
    add_pkt(16'h0800, 8'h00, 3, 0);
    run(0, 0);
    add_pkt(16'h88B5, 8'd2, 1, 0);
    add_pkt(16'h88B5, 8'd3, 1, 0);
    run(0, 0);
    add_pkt(16'h88B5, 8'd1, 4, 0);
    add_pkt(16'h88B5, 8'd1, 4, 0);
    run(2, 0);
    add_pkt(16'h88B5, 8'h07, 2, 0);
    run(1, 0);
    check_val("drop_cnt1", DW'(drop_count), DW'(exp_drops));
    add_pkt(16'h88B5, 8'h09, 2, 1);
    run(1, 0);

    // Reset during beat 2 of a 4-beat SFP frame.
    add_pkt(16'h0800, 8'h00, 4, 0);
    run(0, 2);
    rst_n = 1'b0;
    #1;
    check_val("midrst_valids", DW'({hb3_v, hb2_v, hb1_v, sfp_v}), 0);
    check_val("midrst_drops", DW'(drop_count), 0);
    src_q.delete();
    exp_q.delete();
    in_drop = 0;
    exp_drops = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    add_pkt(16'h88B5, 8'd1, 2, 0);
    run(0, 0);

    // Enough single-beat drops to reach counter saturation.
    for (int i = 0; i < 18; i++) add_pkt(16'h88B5, 8'hFF, 1, 0);
    run(0, 0);
    check_val("drop_sat", DW'(drop_count), DW'(exp_drops));

    // Random mix of frame types, lengths and sink backpressure.
    for (int p = 0; p < 60; p++) begin
      logic [15:0] et;
      logic [7:0]  id;
      int          pick;
      pick = $urandom_range(6);
      id = (pick < 4) ? 8'(pick) : (pick == 4) ? 8'd4 : (pick == 5) ? 8'd7 : 8'hFF;
      et = ($urandom_range(1) == 1) ? 16'h88B5 : 16'(16'h0800 + $urandom_range(3));
      add_pkt(et, id, $urandom_range(1, 5), $urandom_range(9) == 0);
      if (p % 10 == 9) begin
        run(1, 0);
        check_val("drop_cnt_rand", DW'(drop_count), DW'(exp_drops));
      end
    end
    run(1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
